// File: rtl/synth_voice_bank.sv
// Bus-mapped multi-voice phase-accumulator synthesiser. On each sample tick a
// sequential FSM steps and mixes the voices, applies master volume and saturates.
module synth_voice_bank #(
    parameter int unsigned VOICES  = 4,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned OUT_W   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             sample,
    output logic [OUT_W-1:0] out,
    output logic             busy
);

    localparam int unsigned ACC_W = 16 + $clog2(VOICES);
    localparam int unsigned VW    = $clog2(VOICES + 1);
    localparam int unsigned IW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int unsigned SH    = 24 - OUT_W;
    localparam int unsigned PW    = ACC_W + 8;

    typedef enum logic [1:0] {S_IDLE, S_PHASE, S_MAC, S_SCALE} state_t;

    logic [PHASE_W-1:0] r_freq  [VOICES];
    logic [PHASE_W-1:0] r_phase [VOICES];
    logic [15:0]        r_lfsr  [VOICES];
    logic [1:0]         r_wave  [VOICES];
    logic               r_en    [VOICES];
    logic [7:0]         r_duty  [VOICES];
    logic [7:0]         r_vol   [VOICES];
    logic [7:0]         r_master;
    logic               r_clip;
    logic               r_ovr;
    logic               r_ready;
    logic [31:0]        r_rdata;
    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [VW-1:0]      r_v;
    logic [OUT_W-1:0]   r_out;

    // Bus decode
    logic [5:0]  w_word;
    logic [3:0]  w_vsel;
    logic [1:0]  w_field;
    logic [IW-1:0] w_vi;
    logic        w_is_master;
    logic        w_is_status;
    logic        w_vhit;
    logic        w_acc_en;
    logic        w_wr;
    logic [31:0] w_rd;
    logic [31:0] w_freq_old;
    logic [31:0] w_freq_mrg;
    logic        w_unused;

    assign w_word      = addr[7:2];
    assign w_vsel      = w_word[5:2];
    assign w_field     = w_word[1:0];
    assign w_vi        = w_vsel[IW-1:0];
    assign w_is_master = (w_word == 6'h20);
    assign w_is_status = (w_word == 6'h21);
    // Global registers take priority over any voice slot that would alias them.
    assign w_vhit      = !w_is_master && !w_is_status && ({28'b0, w_vsel} < 32'(VOICES));
    assign w_acc_en    = valid && !r_ready;
    assign w_wr        = w_acc_en && (wstrb != 4'b0000);
    assign w_unused    = &{1'b0, addr[31:8], addr[1:0]};

    always_comb begin
        w_freq_old = '0;
        w_freq_old[PHASE_W-1:0] = r_freq[w_vi];
        w_freq_mrg = w_freq_old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) w_freq_mrg[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_vhit) begin
            case (w_field)
                2'd0: w_rd[PHASE_W-1:0] = r_freq[w_vi];
                2'd1: w_rd = {16'b0, r_duty[w_vi], 5'b0, r_en[w_vi], r_wave[w_vi]};
                2'd2: w_rd[7:0] = r_vol[w_vi];
                default: w_rd[PHASE_W-1:0] = r_phase[w_vi];
            endcase
        end else if (w_is_master) begin
            w_rd[7:0] = r_master;
        end else if (w_is_status) begin
            w_rd[2:0] = {r_ovr, r_clip, busy};
        end
    end

    // Voice datapath
    logic [IW-1:0]      w_ci;
    logic [PHASE_W:0]   w_sum;
    logic [15:0]        w_lfsr_nx;
    logic [7:0]         w_p;
    logic [7:0]         w_wave;
    logic [15:0]        w_prod;
    logic [PW-1:0]      w_scaled;
    logic               w_sat;
    logic               w_clip_set;
    logic               w_ovr_set;

    assign w_ci      = r_v[IW-1:0];
    assign w_sum     = {1'b0, r_phase[w_ci]} + {1'b0, r_freq[w_ci]};
    assign w_lfsr_nx = {r_lfsr[w_ci][14:0],
                        r_lfsr[w_ci][15] ^ r_lfsr[w_ci][13] ^ r_lfsr[w_ci][12] ^ r_lfsr[w_ci][10]};
    assign w_p       = r_phase[w_ci][PHASE_W-1 -: 8];

    always_comb begin
        w_wave = '0;
        case (r_wave[w_ci])
            2'd0:    w_wave = (w_p < r_duty[w_ci]) ? 8'hFF : 8'h00;
            2'd1:    w_wave = w_p;
            2'd2:    w_wave = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
            default: w_wave = r_lfsr[w_ci][7:0];
        endcase
    end

    assign w_prod     = 16'(w_wave) * 16'(r_vol[w_ci]);
    assign w_scaled   = (PW'(r_acc) * PW'(r_master)) >> SH;
    assign w_sat      = |w_scaled[PW-1:OUT_W];
    assign busy       = (r_state != S_IDLE);
    assign w_clip_set = (r_state == S_SCALE) && w_sat;
    assign w_ovr_set  = sample && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample) w_next = S_PHASE;
            S_PHASE: w_next = S_MAC;
            S_MAC:   w_next = (r_v == VW'(VOICES - 1)) ? S_SCALE : S_PHASE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_v   <= '0;
            r_out <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                r_phase[i] <= '0;
                r_lfsr[i]  <= 16'hACE1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sample) begin
                        r_acc <= '0;
                        r_v   <= '0;
                    end
                end
                S_PHASE: begin
                    if (r_en[w_ci]) begin
                        r_phase[w_ci] <= w_sum[PHASE_W-1:0];
                        if (w_sum[PHASE_W]) r_lfsr[w_ci] <= w_lfsr_nx;
                    end
                end
                S_MAC: begin
                    if (r_en[w_ci]) r_acc <= r_acc + ACC_W'(w_prod);
                    r_v <= r_v + 1'b1;
                end
                default: r_out <= w_sat ? '1 : w_scaled[OUT_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_master <= 8'hFF;
            r_clip   <= 1'b0;
            r_ovr    <= 1'b0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                r_freq[i] <= '0;
                r_wave[i] <= '0;
                r_en[i]   <= 1'b0;
                r_duty[i] <= '0;
                r_vol[i]  <= '0;
            end
        end else begin
            r_ready <= w_acc_en;
            r_rdata <= w_acc_en ? w_rd : '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (w_wr && w_vhit && (w_vi == IW'(i))) begin
                    case (w_field)
                        2'd0: r_freq[i] <= w_freq_mrg[PHASE_W-1:0];
                        2'd1: begin
                            if (wstrb[0]) begin
                                r_wave[i] <= wdata[1:0];
                                r_en[i]   <= wdata[2];
                            end
                            if (wstrb[1]) r_duty[i] <= wdata[15:8];
                        end
                        2'd2: if (wstrb[0]) r_vol[i] <= wdata[7:0];
                        default: ;
                    endcase
                end
            end
            if (w_wr && w_is_master && wstrb[0]) r_master <= wdata[7:0];
            // Hardware set wins over a simultaneous write-one-to-clear.
            if (w_wr && w_is_status && wstrb[0]) begin
                if (wdata[1]) r_clip <= 1'b0;
                if (wdata[2]) r_ovr  <= 1'b0;
            end
            if (w_clip_set) r_clip <= 1'b1;
            if (w_ovr_set)  r_ovr  <= 1'b1;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;
    assign out   = r_out;

endmodule
